// File: rtl/bin_bbox.sv
// Bounding-box tracker for a 1-bit thresholded pixel stream.
// Accumulates foreground extent and count per frame; publishes one result per completed frame.
module bin_bbox #(
    parameter int XW = 12,
    parameter int YW = 12,
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eol,
    input  logic          in_eof,
    input  logic          in_bin,
    input  logic [CW-1:0] cfg_min_pix,
    output logic          bbox_valid,
    output logic          bbox_found,
    output logic [XW-1:0] bbox_xmin,
    output logic [XW-1:0] bbox_xmax,
    output logic [YW-1:0] bbox_ymin,
    output logic [YW-1:0] bbox_ymax,
    output logic [CW-1:0] bbox_cnt,
    output logic          err_sync
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [XW-1:0] X_MAX = {XW{1'b1}};
    localparam logic [YW-1:0] Y_MAX = {YW{1'b1}};
    localparam logic [CW-1:0] C_MAX = {CW{1'b1}};

    logic [0:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_eolPrev;
    logic [XW-1:0] r_xmin;
    logic [XW-1:0] r_xmax;
    logic [YW-1:0] r_ymin;
    logic [YW-1:0] r_ymax;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [XW-1:0] w_bXmin;
    logic [XW-1:0] w_bXmax;
    logic [YW-1:0] w_bYmin;
    logic [YW-1:0] w_bYmax;
    logic [CW-1:0] w_bCnt;
    logic          w_first;
    logic [XW-1:0] w_nXmin;
    logic [XW-1:0] w_nXmax;
    logic [YW-1:0] w_nYmin;
    logic [YW-1:0] w_nYmax;
    logic [CW-1:0] w_nCnt;
    logic          w_found;

    // Outside a frame only a start-of-frame beat is meaningful.
    assign w_accept = in_valid && (in_sof || (r_state == S_ACTIVE));

    // Coordinates saturate rather than wrap so oversized lines clamp to the edge column/line.
    assign w_x = (in_sof || r_eolPrev) ? '0 :
                 ((r_x == X_MAX) ? r_x : r_x + XW'(1));
    assign w_y = in_sof ? '0 :
                 (r_eolPrev ? ((r_y == Y_MAX) ? r_y : r_y + YW'(1)) : r_y);

    // A start-of-frame beat folds into empty accumulators, whatever the old frame held.
    assign w_bXmin = in_sof ? '0 : r_xmin;
    assign w_bXmax = in_sof ? '0 : r_xmax;
    assign w_bYmin = in_sof ? '0 : r_ymin;
    assign w_bYmax = in_sof ? '0 : r_ymax;
    assign w_bCnt  = in_sof ? '0 : r_cnt;
    assign w_first = (w_bCnt == '0);

    always_comb begin
        w_nXmin = w_bXmin;
        w_nXmax = w_bXmax;
        w_nYmin = w_bYmin;
        w_nYmax = w_bYmax;
        w_nCnt  = w_bCnt;
        if (in_bin) begin
            if (w_first) begin
                w_nXmin = w_x;
                w_nXmax = w_x;
                w_nYmin = w_y;
                w_nYmax = w_y;
            end else begin
                if (w_x < w_bXmin) w_nXmin = w_x;
                if (w_x > w_bXmax) w_nXmax = w_x;
                if (w_y < w_bYmin) w_nYmin = w_y;
                if (w_y > w_bYmax) w_nYmax = w_y;
            end
            if (w_bCnt != C_MAX) w_nCnt = w_bCnt + CW'(1);
        end
    end

    assign w_found = (w_nCnt != '0) && (w_nCnt >= cfg_min_pix);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_eolPrev  <= 1'b0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymin     <= '0;
            r_ymax     <= '0;
            r_cnt      <= '0;
            bbox_valid <= 1'b0;
            bbox_found <= 1'b0;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            bbox_cnt   <= '0;
            err_sync   <= 1'b0;
        end else begin
            bbox_valid <= 1'b0;
            err_sync   <= 1'b0;
            if (w_accept) begin
                r_x       <= w_x;
                r_y       <= w_y;
                r_eolPrev <= in_eol;
                r_xmin    <= w_nXmin;
                r_xmax    <= w_nXmax;
                r_ymin    <= w_nYmin;
                r_ymax    <= w_nYmax;
                r_cnt     <= w_nCnt;
                // A new frame start while one is open drops the old frame silently except for this flag.
                err_sync  <= in_sof && (r_state == S_ACTIVE);
                if (in_eof) begin
                    r_state    <= S_IDLE;
                    bbox_valid <= 1'b1;
                    bbox_cnt   <= w_nCnt;
                    bbox_found <= w_found;
                    bbox_xmin  <= w_found ? w_nXmin : '0;
                    bbox_xmax  <= w_found ? w_nXmax : '0;
                    bbox_ymin  <= w_found ? w_nYmin : '0;
                    bbox_ymax  <= w_found ? w_nYmax : '0;
                end else begin
                    r_state <= S_ACTIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_bbox.sv
// Scoreboard bench for bin_bbox: frames are built from a small image, expected boxes
// are computed from the image and queued, and each bbox_valid pops and compares one entry.
module tb_bin_bbox;

    typedef struct {
        bit found;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic        in_eol;
    logic        in_eof;
    logic        in_bin;
    logic [19:0] cfg_min_pix;

    logic        bbox_valid;
    logic        bbox_found;
    logic [11:0] bbox_xmin;
    logic [11:0] bbox_xmax;
    logic [11:0] bbox_ymin;
    logic [11:0] bbox_ymax;
    logic [19:0] bbox_cnt;
    logic        err_sync;

    logic        s_valid;
    logic        s_found;
    logic [2:0]  s_xmin;
    logic [2:0]  s_xmax;
    logic [11:0] s_ymin;
    logic [11:0] s_ymax;
    logic [19:0] s_cnt;
    logic        s_err;

    int   cmpCount = 0;
    int   failCount = 0;
    int   errSeen = 0;
    int   errExpected = 0;
    int   smallSeen = 0;
    bit   smallArmed = 1'b0;
    res_t q[$];
    res_t monE;
    bit   img [0:3][0:15];

    always #5 clk = ~clk;

    bin_bbox dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .in_eof(in_eof), .in_bin(in_bin), .cfg_min_pix(cfg_min_pix),
        .bbox_valid(bbox_valid), .bbox_found(bbox_found), .bbox_xmin(bbox_xmin),
        .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .bbox_cnt(bbox_cnt), .err_sync(err_sync)
    );

    bin_bbox #(.XW(3)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .in_eof(in_eof), .in_bin(in_bin), .cfg_min_pix(cfg_min_pix),
        .bbox_valid(s_valid), .bbox_found(s_found), .bbox_xmin(s_xmin),
        .bbox_xmax(s_xmax), .bbox_ymin(s_ymin), .bbox_ymax(s_ymax),
        .bbox_cnt(s_cnt), .err_sync(s_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every result the DUT publishes must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && bbox_valid) begin
            if (q.size() == 0) begin
                checkOutput("spuriousValid", 32'(bbox_valid), 32'd0);
            end else begin
                monE = q.pop_front();
                checkOutput("found", 32'(bbox_found), 32'(monE.found));
                checkOutput("xmin", 32'(bbox_xmin), monE.xmin);
                checkOutput("xmax", 32'(bbox_xmax), monE.xmax);
                checkOutput("ymin", 32'(bbox_ymin), monE.ymin);
                checkOutput("ymax", 32'(bbox_ymax), monE.ymax);
                checkOutput("cnt", 32'(bbox_cnt), monE.cnt);
            end
        end
        if (rst && err_sync) errSeen++;
        if (rst && s_valid && smallArmed) begin
            smallSeen++;
            checkOutput("smallFound", 32'(s_found), 32'd1);
            checkOutput("smallXmin", 32'(s_xmin), 32'd1);
            checkOutput("smallXmax", 32'(s_xmax), 32'd7);
            checkOutput("smallYmax", 32'(s_ymax), 32'd1);
            checkOutput("smallCnt", 32'(s_cnt), 32'd2);
        end
    end

    task automatic clearImg();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 1'b0;
    endtask

    function automatic res_t computeExpected(input int w, input int h, input int cfg);
        res_t r;
        r = '{found: 1'b0, xmin: 0, xmax: 0, ymin: 0, ymax: 0, cnt: 0};
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (img[y][x]) begin
                    if (r.cnt == 0) begin
                        r.xmin = x; r.xmax = x; r.ymin = y; r.ymax = y;
                    end else begin
                        if (x < r.xmin) r.xmin = x;
                        if (x > r.xmax) r.xmax = x;
                        if (y < r.ymin) r.ymin = y;
                        if (y > r.ymax) r.ymax = y;
                    end
                    r.cnt++;
                end
            end
        end
        r.found = (r.cnt != 0) && (r.cnt >= cfg);
        if (!r.found) begin
            r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0;
        end
        return r;
    endfunction

    // One valid beat, optionally preceded by up to four invalid cycles carrying junk flags.
    task automatic applyStimulus(input bit sof, input bit eol, input bit eof, input bit bin,
                                 input int gapPct);
        int g = 0;
        while (gapPct > 0 && g < 4 && $urandom_range(99) < gapPct) begin
            in_valid = 1'b0;
            in_sof   = 1'($urandom_range(1));
            in_eol   = 1'($urandom_range(1));
            in_eof   = 1'($urandom_range(1));
            in_bin   = 1'($urandom_range(1));
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_eol   = eol;
        in_eof   = eof;
        in_bin   = bin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
        in_eof   = 1'b0;
        in_bin   = 1'b0;
    endtask

    task automatic sendFrame(input int w, input int h, input int cfg, input int gapPct);
        q.push_back(computeExpected(w, h, cfg));
        cfg_min_pix = 20'(cfg);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                applyStimulus(x == 0 && y == 0, x == w - 1, x == w - 1 && y == h - 1,
                              img[y][x], gapPct);
    endtask

    // Starts a frame and stops before pixel (stopX, stopY) without ever sending eof.
    task automatic sendPartial(input int w, input int stopX, input int stopY);
        for (int y = 0; y <= stopY; y++)
            for (int x = 0; x < w; x++)
                if (y < stopY || x < stopX)
                    applyStimulus(x == 0 && y == 0, x == w - 1, 1'b0, img[y][x], 0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic loadBasicImg();
        clearImg();
        img[1][2] = 1'b1;
        img[1][5] = 1'b1;
        img[3][3] = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_eof = 1'b0; in_bin = 1'b0;
        cfg_min_pix = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", 32'(bbox_valid), 32'd0);
        checkOutput("resetFound", 32'(bbox_found), 32'd0);
        checkOutput("resetXmax", 32'(bbox_xmax), 32'd0);
        checkOutput("resetCnt", 32'(bbox_cnt), 32'd0);
        checkOutput("resetErr", 32'(err_sync), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic 8x4 frame, threshold 1 then 4");
        loadBasicImg();
        sendFrame(8, 4, 1, 0);
        waitDrain();
        sendFrame(8, 4, 4, 0);
        waitDrain();

        $display("[TB] empty frame, threshold 0");
        clearImg();
        sendFrame(8, 4, 0, 0);
        waitDrain();

        $display("[TB] single-pixel frame then 4x2 frame");
        clearImg();
        img[0][0] = 1'b1;
        sendFrame(1, 1, 1, 0);
        waitDrain();
        clearImg();
        img[1][3] = 1'b1;
        sendFrame(4, 2, 1, 0);
        waitDrain();

        $display("[TB] gappy frame and stray beats");
        loadBasicImg();
        sendFrame(8, 4, 1, 50);
        waitDrain();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("strayQueue", 32'(q.size()), 32'd0);

        $display("[TB] frame aborted by sof at (4,2)");
        clearImg();
        img[0][0] = 1'b1;
        img[1][7] = 1'b1;
        sendPartial(8, 4, 2);
        loadBasicImg();
        errExpected++;
        sendFrame(8, 4, 1, 0);
        waitDrain();
        checkOutput("errCount", 32'(errSeen), 32'(errExpected));

        $display("[TB] reset mid-frame");
        sendPartial(8, 3, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("midRstFound", 32'(bbox_found), 32'd0);
        checkOutput("midRstXmax", 32'(bbox_xmax), 32'd0);
        checkOutput("midRstYmax", 32'(bbox_ymax), 32'd0);
        checkOutput("midRstCnt", 32'(bbox_cnt), 32'd0);
        clearImg();
        img[0][6] = 1'b1;
        img[2][1] = 1'b1;
        sendFrame(8, 3, 2, 0);
        waitDrain();

        $display("[TB] 10-pixel lines, narrow instance clamps x");
        clearImg();
        img[0][1] = 1'b1;
        img[1][9] = 1'b1;
        smallArmed = 1'b1;
        sendFrame(10, 2, 1, 0);
        waitDrain();
        @(posedge clk); #1;
        smallArmed = 1'b0;
        checkOutput("smallSeen", 32'(smallSeen), 32'd1);
        checkOutput("errFinal", 32'(errSeen), 32'(errExpected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
